// File: rtl/reg_file_pkg.sv
// Shared defaults and derived widths for the ID-stage register file and its return stack.
package reg_file_pkg;

  localparam int DATA_W_DEF      = 19;
  localparam int NREGS_DEF       = 8;
  localparam int PC_W_DEF        = 8;
  localparam int STACK_DEPTH_DEF = 8;

  localparam int RADDR_W_DEF = $clog2(NREGS_DEF);
  localparam int SP_W_DEF    = $clog2(STACK_DEPTH_DEF + 1);

  // Encoding matches the {push, pop} request pair.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } stk_op_e;

endpackage

// File: rtl/pc_stack.sv
// Hardware return stack: LIFO of return addresses, saturating pointer,
// registered pop result and sticky overflow/underflow flags.
module pc_stack
  import reg_file_pkg::*;
#(
  parameter  int PC_W        = PC_W_DEF,
  parameter  int STACK_DEPTH = STACK_DEPTH_DEF,
  localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] stack_pc_i,
  input  logic            err_clr_i,
  output logic [PC_W-1:0] pop_pc_o,
  output logic            pop_valid_o,
  output logic [SP_W-1:0] sp_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            ovf_o,
  output logic            unf_o
);

  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [PC_W-1:0]  stack_q [STACK_DEPTH];
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [PC_W-1:0]  pop_pc_q, pop_pc_d;
  logic             pop_vld_q, pop_vld_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             ovf_set, unf_set;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;
  logic             full, empty;
  stk_op_e          op;

  assign full    = (sp_q == SP_W'(STACK_DEPTH));
  assign empty   = (sp_q == '0);
  assign top_idx = IDX_W'(sp_q - SP_W'(1));
  assign op      = stk_op_e'({push_i, pop_i});

  always_comb begin
    sp_d      = sp_q;
    pop_pc_d  = pop_pc_q;
    pop_vld_d = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = '0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    unique case (op)
      OP_PUSH: begin
        if (!full) begin
          wr_en  = 1'b1;
          wr_idx = IDX_W'(sp_q);
          sp_d   = sp_q + SP_W'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty) begin
          pop_pc_d  = stack_q[top_idx];
          pop_vld_d = 1'b1;
          sp_d      = sp_q - SP_W'(1);
        end else begin
          unf_set = 1'b1;
        end
      end
      OP_BOTH: begin
        // RET then CALL: the popped slot is reused for the new return address.
        pop_vld_d = 1'b1;
        if (!empty) begin
          pop_pc_d = stack_q[top_idx];
          wr_en    = 1'b1;
          wr_idx   = top_idx;
        end else begin
          pop_pc_d = stack_pc_i;
        end
      end
      default: ;
    endcase
    ovf_d = err_clr_i ? 1'b0 : (ovf_q | ovf_set);
    unf_d = err_clr_i ? 1'b0 : (unf_q | unf_set);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
      sp_q      <= '0;
      pop_pc_q  <= '0;
      pop_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      if (wr_en) stack_q[wr_idx] <= stack_pc_i;
      sp_q      <= sp_d;
      pop_pc_q  <= pop_pc_d;
      pop_vld_q <= pop_vld_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign pop_pc_o    = pop_pc_q;
  assign pop_valid_o = pop_vld_q;
  assign sp_o        = sp_q;
  assign full_o      = full;
  assign empty_o     = empty;
  assign ovf_o       = ovf_q;
  assign unf_o       = unf_q;

endmodule

// File: rtl/reg_stack_file.sv
// ID-stage general register array (2 async reads, 1 WB write) plus return stack.
// Define REG_BYPASS_EN to forward same-cycle WB write data onto the read ports.
module reg_stack_file
  import reg_file_pkg::*;
#(
  parameter  int DATA_W      = DATA_W_DEF,
  parameter  int NREGS       = NREGS_DEF,
  parameter  int PC_W        = PC_W_DEF,
  parameter  int STACK_DEPTH = STACK_DEPTH_DEF,
  localparam int RADDR_W     = $clog2(NREGS),
  localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               WB_regwrite,
  input  logic [RADDR_W-1:0] ws,
  input  logic [DATA_W-1:0]  wd,
  input  logic [RADDR_W-1:0] rs1,
  input  logic [RADDR_W-1:0] rs2,
  output logic [DATA_W-1:0]  ID_rd1,
  output logic [DATA_W-1:0]  ID_rd2,
  input  logic               ID_push,
  input  logic               ID_pop,
  input  logic [PC_W-1:0]    stack_pc,
  output logic [PC_W-1:0]    pop_pc,
  output logic               pop_valid,
  output logic [SP_W-1:0]    sp,
  output logic               stk_full,
  output logic               stk_empty,
  output logic               stk_ovf,
  output logic               stk_unf,
  input  logic               err_clr
);

  logic [DATA_W-1:0] regs_q [NREGS];

  // r0 is an ordinary register here, not hard-wired to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (WB_regwrite) begin
      regs_q[ws] <= wd;
    end
  end

`ifdef REG_BYPASS_EN
  assign ID_rd1 = (WB_regwrite && (ws == rs1)) ? wd : regs_q[rs1];
  assign ID_rd2 = (WB_regwrite && (ws == rs2)) ? wd : regs_q[rs2];
`else
  assign ID_rd1 = regs_q[rs1];
  assign ID_rd2 = regs_q[rs2];
`endif

  pc_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_pc_stack (
    .clk         (clk),
    .rst         (reset),
    .push_i      (ID_push),
    .pop_i       (ID_pop),
    .stack_pc_i  (stack_pc),
    .err_clr_i   (err_clr),
    .pop_pc_o    (pop_pc),
    .pop_valid_o (pop_valid),
    .sp_o        (sp),
    .full_o      (stk_full),
    .empty_o     (stk_empty),
    .ovf_o       (stk_ovf),
    .unf_o       (stk_unf)
  );

endmodule

// File: tb/tb_reg_stack_file.sv
// Self-checking bench for reg_stack_file: register file, bypass, return stack, async reset.
module tb_reg_stack_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        WB_regwrite;
  logic [2:0]  ws, rs1, rs2;
  logic [18:0] wd, ID_rd1, ID_rd2;
  logic        ID_push, ID_pop, err_clr;
  logic [7:0]  stack_pc, pop_pc;
  logic        pop_valid, stk_full, stk_empty, stk_ovf, stk_unf;
  logic [3:0]  sp;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the stack plus scoreboard of expected pop results.
  logic [7:0] m_stk [$];
  logic [7:0] exp_q [$];
  logic       m_ovf, m_unf, exp_vld;
  logic [7:0] m_pop_pc;

  always #5 clk = ~clk;

  reg_stack_file dut (
    .clk(clk), .reset(reset), .WB_regwrite(WB_regwrite), .ws(ws), .wd(wd),
    .rs1(rs1), .rs2(rs2), .ID_rd1(ID_rd1), .ID_rd2(ID_rd2),
    .ID_push(ID_push), .ID_pop(ID_pop), .stack_pc(stack_pc), .pop_pc(pop_pc),
    .pop_valid(pop_valid), .sp(sp), .stk_full(stk_full), .stk_empty(stk_empty),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf), .err_clr(err_clr)
  );

  task automatic model_clear();
    m_stk.delete();
    exp_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; exp_vld = 1'b0; m_pop_pc = 8'h00;
  endtask

  // One clock of stack stimulus; updates the model and scoreboard, samples #1 after the edge.
  task automatic step(input logic push, input logic pop, input logic [7:0] pc, input logic clr);
    logic v;
    logic [7:0] e;
    int idx;
    @(negedge clk);
    ID_push = push; ID_pop = pop; stack_pc = pc; err_clr = clr;
    v = 1'b0; e = m_pop_pc;
    case ({push, pop})
      2'b10: if (m_stk.size() < 8) m_stk.push_back(pc); else m_ovf = 1'b1;
      2'b01: if (m_stk.size() > 0) begin v = 1'b1; e = m_stk.pop_back(); end else m_unf = 1'b1;
      2'b11: begin
        v = 1'b1;
        if (m_stk.size() > 0) begin
          idx = m_stk.size() - 1;
          e = m_stk[idx];
          m_stk[idx] = pc;
        end else begin
          e = pc;
        end
      end
      default: ;
    endcase
    if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (v) begin exp_q.push_back(e); m_pop_pc = e; end
    exp_vld = v;
    @(posedge clk); #1;
    ID_push = 1'b0; ID_pop = 1'b0; err_clr = 1'b0;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [18:0] d);
    @(negedge clk);
    WB_regwrite = 1'b1; ws = a; wd = d;
    @(posedge clk); #1;
    WB_regwrite = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++; if (sp !== 4'd0) begin n_fail++; $display("FAIL reset_sp got=%0d exp=0", sp); end
    n_tests++; if ({stk_empty, stk_full} !== 2'b10) begin n_fail++; $display("FAIL reset_empty_full got=%b exp=10", {stk_empty, stk_full}); end
    n_tests++; if ({pop_valid, stk_ovf, stk_unf} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {pop_valid, stk_ovf, stk_unf}); end
    n_tests++; if (pop_pc !== 8'h00) begin n_fail++; $display("FAIL reset_pop_pc got=%h exp=00", pop_pc); end
    n_tests++; if (ID_rd1 !== 19'h0) begin n_fail++; $display("FAIL reset_rd1 got=%h exp=0", ID_rd1); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_regfile();
    wr_reg(3'd1, 19'h1A5A5);
    rs1 = 3'd1; rs2 = 3'd2; #1;
    n_tests++; if (ID_rd1 !== 19'h1A5A5) begin n_fail++; $display("FAIL rd1_r1 got=%h exp=1a5a5", ID_rd1); end
    n_tests++; if (ID_rd2 !== 19'h0) begin n_fail++; $display("FAIL rd2_r2 got=%h exp=0", ID_rd2); end
    wr_reg(3'd0, 19'h00005);
    wr_reg(3'd7, 19'h7FFFF);
    rs1 = 3'd0; rs2 = 3'd7; #1;
    n_tests++; if (ID_rd1 !== 19'h00005) begin n_fail++; $display("FAIL rd1_r0 got=%h exp=00005", ID_rd1); end
    n_tests++; if (ID_rd2 !== 19'h7FFFF) begin n_fail++; $display("FAIL rd2_r7 got=%h exp=7ffff", ID_rd2); end
    rs2 = 3'd1; #1;
    n_tests++; if (ID_rd2 !== 19'h1A5A5) begin n_fail++; $display("FAIL rd2_r1 got=%h exp=1a5a5", ID_rd2); end
  endtask

  task automatic test_bypass();
    logic [18:0] exp_pre;
`ifdef REG_BYPASS_EN
    exp_pre = 19'h00F0F;
`else
    exp_pre = 19'h00000;
`endif
    @(negedge clk);
    WB_regwrite = 1'b1; ws = 3'd3; wd = 19'h00F0F; rs1 = 3'd3; rs2 = 3'd7;
    #1;
    n_tests++; if (ID_rd1 !== exp_pre) begin n_fail++; $display("FAIL bypass_pre got=%h exp=%h", ID_rd1, exp_pre); end
    n_tests++; if (ID_rd2 !== 19'h7FFFF) begin n_fail++; $display("FAIL bypass_other got=%h exp=7ffff", ID_rd2); end
    @(posedge clk); #1;
    WB_regwrite = 1'b0; #1;
    n_tests++; if (ID_rd1 !== 19'h00F0F) begin n_fail++; $display("FAIL bypass_post got=%h exp=00f0f", ID_rd1); end
  endtask

  task automatic test_lifo();
    logic [7:0] e;
    logic [7:0] fixed [3];
    fixed[0] = 8'h30; fixed[1] = 8'h20; fixed[2] = 8'h10;
    step(1'b1, 1'b0, 8'h10, 1'b0);
    step(1'b1, 1'b0, 8'h20, 1'b0);
    step(1'b1, 1'b0, 8'h30, 1'b0);
    n_tests++; if (sp !== 4'd3) begin n_fail++; $display("FAIL lifo_sp3 got=%0d exp=3", sp); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      e = exp_q.pop_front();
      n_tests++; if (pop_valid !== 1'b1) begin n_fail++; $display("FAIL lifo_valid%0d got=%b exp=1", i, pop_valid); end
      n_tests++; if (pop_pc !== e || pop_pc !== fixed[i]) begin n_fail++; $display("FAIL lifo_pop%0d got=%h exp=%h", i, pop_pc, fixed[i]); end
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    n_tests++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL lifo_pulse got=%b exp=0", pop_valid); end
    n_tests++; if (sp !== 4'd0 || stk_empty !== 1'b1) begin n_fail++; $display("FAIL lifo_empty got sp=%0d empty=%b exp sp=0 empty=1", sp, stk_empty); end
  endtask

  task automatic test_overflow();
    logic [7:0] e;
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
    n_tests++; if (sp !== 4'd8 || stk_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got sp=%0d full=%b exp sp=8 full=1", sp, stk_full); end
    n_tests++; if (stk_ovf !== m_ovf || stk_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", stk_ovf); end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (pop_pc !== e || pop_pc !== 8'h08) begin n_fail++; $display("FAIL ovf_pop got=%h exp=08", pop_pc); end
    n_tests++; if (stk_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", stk_ovf); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_tests++; if (stk_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got=%b exp=0", stk_ovf); end
    step(1'b1, 1'b0, 8'hA8, 1'b0);
    step(1'b1, 1'b0, 8'hA9, 1'b1);
    n_tests++; if (stk_ovf !== m_ovf || stk_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr_wins got=%b exp=0", stk_ovf); end
    step(1'b1, 1'b1, 8'hBB, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (pop_pc !== e || sp !== 4'd8 || stk_ovf !== 1'b0) begin n_fail++; $display("FAIL full_both got pc=%h sp=%0d ovf=%b exp pc=%h sp=8 ovf=0", pop_pc, sp, stk_ovf, e); end
    while (m_stk.size() > 0) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      e = exp_q.pop_front();
      n_tests++; if (pop_valid !== 1'b1 || pop_pc !== e) begin n_fail++; $display("FAIL drain got v=%b pc=%h exp v=1 pc=%h", pop_valid, pop_pc, e); end
    end
  endtask

  task automatic test_underflow_simul();
    logic [7:0] e;
    step(1'b0, 1'b1, 8'h00, 1'b0);
    n_tests++; if (pop_valid !== 1'b0 || stk_unf !== 1'b1 || sp !== 4'd0) begin n_fail++; $display("FAIL unf got v=%b unf=%b sp=%0d exp v=0 unf=1 sp=0", pop_valid, stk_unf, sp); end
    n_tests++; if (pop_pc !== m_pop_pc) begin n_fail++; $display("FAIL unf_hold got=%h exp=%h", pop_pc, m_pop_pc); end
    step(1'b1, 1'b0, 8'h11, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (pop_pc !== e || pop_pc !== 8'h22 || sp !== 4'd2 || pop_valid !== 1'b1) begin n_fail++; $display("FAIL both_pc got pc=%h sp=%0d exp pc=22 sp=2", pop_pc, sp); end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (pop_pc !== e || pop_pc !== 8'h55) begin n_fail++; $display("FAIL both_next got=%h exp=55", pop_pc); end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (pop_pc !== e || pop_pc !== 8'h11) begin n_fail++; $display("FAIL both_last got=%h exp=11", pop_pc); end
    step(1'b1, 1'b1, 8'h77, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (pop_pc !== 8'h77 || pop_valid !== 1'b1 || sp !== 4'd0) begin n_fail++; $display("FAIL empty_both got pc=%h v=%b sp=%0d exp pc=77 v=1 sp=0", pop_pc, pop_valid, sp); end
    n_tests++; if (stk_unf !== m_unf || stk_unf !== 1'b1) begin n_fail++; $display("FAIL unf_sticky got=%b exp=1", stk_unf); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_tests++; if (stk_unf !== 1'b0) begin n_fail++; $display("FAIL unf_clr got=%b exp=0", stk_unf); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    n_tests++; if (sp !== 4'd4 || pop_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre got sp=%0d v=%b exp sp=4 v=1", sp, pop_valid); end
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    n_tests++; if (sp !== 4'd0 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL arst_now got sp=%0d v=%b exp sp=0 v=0", sp, pop_valid); end
    n_tests++; if (pop_pc !== 8'h00 || stk_empty !== 1'b1) begin n_fail++; $display("FAIL arst_pc got pc=%h empty=%b exp pc=00 empty=1", pop_pc, stk_empty); end
    for (int r = 0; r < 8; r++) begin
      rs1 = 3'(r); rs2 = 3'(7 - r); #1;
      n_tests++; if (ID_rd1 !== 19'h0 || ID_rd2 !== 19'h0) begin n_fail++; $display("FAIL arst_reg%0d got rd1=%h rd2=%h exp 0", r, ID_rd1, ID_rd2); end
    end
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    n_tests++; if (sp !== 4'd1) begin n_fail++; $display("FAIL arst_resume got sp=%0d exp=1", sp); end
  endtask

  initial begin
    reset = 1'b1; WB_regwrite = 1'b0; ws = '0; wd = '0; rs1 = '0; rs2 = '0;
    ID_push = 1'b0; ID_pop = 1'b0; stack_pc = '0; err_clr = 1'b0;
    model_clear();
    test_reset();
    test_regfile();
    test_bypass();
    test_lifo();
    test_overflow();
    test_underflow_simul();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_stack_file.md
Name: reg_stack_file

Overview:
- Parametrised successor to the CPU's ID-stage register file.
- Provides an NREGS x DATA_W general register array with two asynchronous read ports and one write port (WB stage).
- The PC stack is split out into a dedicated hardware return stack of configurable depth, with full/empty/overflow/underflow status and a registered pop result.
- Sits in the ID stage. WB drives the write port; ID drives push/pop for CALL/RET.

Parameters:
- DATA_W, 19, register data width.
- NREGS, 8, number of general registers (power of 2, >=2).
- RADDR_W, $clog2(NREGS), register address width (derived, do not override).
- PC_W, 8, width of a stacked return address.
- STACK_DEPTH, 8, number of stack entries (>=2).
- SP_W, $clog2(STACK_DEPTH+1), stack pointer width (derived).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- WB_regwrite  in  1  write enable for register array.
- ws  in  RADDR_W  write register index.
- wd  in  DATA_W  write data.
- rs1  in  RADDR_W  read index, port 1.
- rs2  in  RADDR_W  read index, port 2.
- ID_rd1  out  DATA_W  read data, port 1 (combinational).
- ID_rd2  out  DATA_W  read data, port 2 (combinational).
- ID_push  in  1  push stack_pc onto return stack.
- ID_pop  in  1  pop top of return stack.
- stack_pc  in  PC_W  return address to push.
- pop_pc  out  PC_W  popped address (registered).
- pop_valid  out  1  one-cycle pulse: pop_pc valid this cycle.
- sp  out  SP_W  current occupancy, 0..STACK_DEPTH.
- stk_full  out  1  sp == STACK_DEPTH (combinational from sp).
- stk_empty  out  1  sp == 0 (combinational from sp).
- stk_ovf  out  1  sticky overflow flag.
- stk_unf  out  1  sticky underflow flag.
- err_clr  in  1  synchronous clear of stk_ovf/stk_unf.

Behaviour:
- Reset:
  - All registers are 0, stack entries are 0, sp=0.
  - pop_pc=0, pop_valid=0, stk_ovf=0, stk_unf=0.
- Register write: when WB_regwrite=1, reg[ws]<=wd on the rising edge. Every register, r0 included, is writable.
- Register read: ID_rd1/ID_rd2 = reg[rs1]/reg[rs2], combinational, zero latency.
- Stack write: stack[sp]<=stack_pc.
- pop_valid defaults to 0 every cycle and is high for exactly one cycle after an accepted pop.
- Push only:
  - If not full: stack write, then sp<=sp+1.
  - If full: push is ignored, sp and entries are unchanged, and stk_ovf<=1.
- Pop only:
  - If not empty: pop_pc<=stack[sp-1], pop_valid<=1, sp<=sp-1.
  - If empty: ignored, pop_valid<=0, pop_pc holds, stk_unf<=1.
- Push and pop in the same cycle (RET then CALL):
  - Not empty, including full: pop_pc<=stack[sp-1], pop_valid<=1, stack[sp-1]<=stack_pc, sp unchanged, no flags.
  - Empty: pop_pc<=stack_pc, pop_valid<=1, no state change, no flags.
- Flags:
  - err_clr has priority over a same-cycle flag set (clear wins).
  - Flags are not cleared by a later successful push or pop.
- Reset asserted mid-operation: state clears asynchronously and any in-flight pop_valid pulse is dropped.
- No pointer wrap-around: sp saturates at 0 and STACK_DEPTH.

Optional Feature:
- Macro: REG_BYPASS_EN.
- Defined: write-through bypass. If WB_regwrite=1 and ws==rs1 (or rs2), ID_rd1 (or ID_rd2) returns wd in the same cycle, removing the WB->ID hazard.
- Undefined: reads return the stored value; the new value is visible the cycle after the write.

Decomposition:
- Package reg_file_pkg holds the DATA_W/PC_W/NREGS/STACK_DEPTH defaults and the width-derivation constants.
- Sub-module pc_stack contains the return stack, sp, the four status outputs, pop_pc/pop_valid and the flag logic. The top level holds the register array and bypass muxing.

Test Plan:
- Write/read: reset, then WB_regwrite=1, ws=1, wd=19'h1A5A5 for one edge; set rs1=1 -> ID_rd1=19'h1A5A5. With rs2=2 -> ID_rd2=0.
- Bypass: WB_regwrite=1, ws=3, wd=19'h00F0F, rs1=3 in the same cycle -> ID_rd1=19'h00F0F before the edge with REG_BYPASS_EN defined, and 0 without it.
- Push/pop LIFO: push 8'h10, 8'h20, 8'h30 -> sp=3. Then pop three times -> pop_pc is 8'h30, 8'h20, 8'h10, each with a one-cycle pop_valid; finally sp=0 and stk_empty=1.
- Overflow: push 9 times (8'h01..8'h09) with STACK_DEPTH=8 -> sp=8, stk_full=1, stk_ovf=1. A subsequent pop returns 8'h08. err_clr -> stk_ovf=0.
- Underflow and simultaneous ops:
  - Pop when empty -> pop_valid=0, stk_unf=1, sp=0.
  - With sp=2 (top 8'h22), push 8'h55 and pop together -> pop_pc=8'h22, sp=2, and the next pop returns 8'h55.
  - When empty, push 8'h77 and pop together -> pop_pc=8'h77, sp=0.
- Async reset mid-op: assert reset between edges while sp=4 and pop_valid=1 -> sp=0 and pop_valid=0 without waiting for a clock edge; all registers read 0.
